// File: rtl/ifetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Single outstanding imem request; a skid buffer absorbs a response that lands during a load-use stall.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [4:0]  if_id_rs1,
    output logic [4:0]  if_id_rs2
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_DROP = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] skid_reg, skid_next;
    logic [31:0] drop_addr_reg, drop_addr_next;
    logic        if_id_valid_reg, if_id_valid_next;
    logic [31:0] if_id_pc_reg, if_id_pc_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic [31:0] target_pc;
    logic [31:0] pc_plus4;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4  = pc_reg + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            skid_reg        <= NOP_INSTR;
            drop_addr_reg   <= 32'h0;
            if_id_valid_reg <= 1'b0;
            if_id_pc_reg    <= 32'h0;
            if_id_instr_reg <= NOP_INSTR;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            skid_reg        <= skid_next;
            drop_addr_reg   <= drop_addr_next;
            if_id_valid_reg <= if_id_valid_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_instr_reg <= if_id_instr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        skid_next        = skid_reg;
        drop_addr_next   = drop_addr_reg;
        if_id_valid_next = if_id_valid_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_instr_next = if_id_instr_reg;
        case (state_reg)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next          = target_pc;
                    if_id_valid_next = 1'b0;
                    if (!imem_rvalid) begin
                        // The in-flight response must still be consumed before refetching.
                        drop_addr_next = pc_reg;
                        state_next     = WAIT_DROP;
                    end
                end else if (load_use_stall) begin
                    if (imem_rvalid) begin
                        skid_next  = imem_rdata;
                        state_next = HOLD;
                    end
                end else if (imem_rvalid) begin
                    if_id_valid_next = 1'b1;
                    if_id_pc_next    = pc_reg;
                    if_id_instr_next = imem_rdata;
                    pc_next          = pc_plus4;
                end else begin
                    if_id_valid_next = 1'b0;
                end
            end
            WAIT_DROP: begin
                if_id_valid_next = 1'b0;
                if (redirect_valid) begin
                    pc_next = target_pc;
                end
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next          = target_pc;
                    if_id_valid_next = 1'b0;
                    state_next       = FETCH;
                end else if (!load_use_stall) begin
                    if_id_valid_next = 1'b1;
                    if_id_pc_next    = pc_reg;
                    if_id_instr_next = skid_reg;
                    pc_next          = pc_plus4;
                    state_next       = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Request is gated by rst_n so it drops immediately when reset asserts.
    assign imem_req    = rst_n && (state_reg != HOLD);
    assign imem_addr   = (state_reg == WAIT_DROP) ? drop_addr_reg : pc_reg;
    assign if_id_valid = if_id_valid_reg;
    assign if_id_pc    = if_id_pc_reg;
    assign if_id_instr = if_id_instr_reg;
    assign if_id_rs1   = if_id_instr_reg[19:15];
    assign if_id_rs2   = if_id_instr_reg[24:20];

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: memory model returns the address as data with a programmable wait count.
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_use_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;

    int total = 0;
    int bad = 0;
    int latency = 0;
    int lat_cnt = 0;

    ifetch_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_stall(load_use_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2)
    );

    always #5 clk = ~clk;

    // rvalid rises once the current request has waited 'latency' cycles.
    always @(posedge clk) begin
        if (imem_req && !imem_rvalid) lat_cnt <= lat_cnt + 1;
        else                          lat_cnt <= 0;
    end
    assign imem_rvalid = imem_req && (lat_cnt >= latency);
    assign imem_rdata  = imem_addr;

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%0b want=0", imem_req);
        end
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0, NOP}) begin
            bad++; $display("FAIL reset_ifid got=%0b/%h/%h want=0/00000000/%h", if_id_valid, if_id_pc, if_id_instr, NOP);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL first_req got=%0b/%h want=1/00000100", imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, 32'h100, 32'h100, 32'h104}) begin
            bad++; $display("FAIL first_ifid got=%0b/%h/%h addr=%h want=1/00000100/00000100 addr=00000104", if_id_valid, if_id_pc, if_id_instr, imem_addr);
        end
        total++;
        if ({if_id_rs1, if_id_rs2} !== 10'd0) begin
            bad++; $display("FAIL first_rs got=%0d/%0d want=0/0", if_id_rs1, if_id_rs2);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'h104, 32'h108}) begin
            bad++; $display("FAIL second_ifid got=%0b/%h addr=%h want=1/00000104 addr=00000108", if_id_valid, if_id_pc, imem_addr);
        end
        $display("test_reset done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_stall;
        load_use_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({imem_req, if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 1'b1, 32'h104, 32'h104}) begin
                bad++; $display("FAIL stall_hold%0d got req=%0b ifid=%0b/%h/%h want req=0 ifid=1/00000104/00000104", i, imem_req, if_id_valid, if_id_pc, if_id_instr);
            end
        end
        load_use_stall = 1'b0;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr} !== {1'b1, 32'h108, 32'h108, 1'b1, 32'h10C}) begin
            bad++; $display("FAIL stall_release got=%0b/%h/%h req=%0b addr=%h want=1/00000108/00000108 req=1 addr=0000010c", if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h10C, 32'h10C}) begin
            bad++; $display("FAIL stall_next got=%0b/%h/%h want=1/0000010c/0000010c", if_id_valid, if_id_pc, if_id_instr);
        end
        $display("test_stall done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_redirect_latency;
        int n;
        redirect_valid = 1'b1; redirect_pc = 32'h120;
        @(negedge clk);
        redirect_valid = 1'b0;
        latency = 2;
        total++;
        if ({if_id_valid, imem_addr} !== {1'b0, 32'h120}) begin
            bad++; $display("FAIL redir120 got valid=%0b addr=%h want valid=0 addr=00000120", if_id_valid, imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h120, 1'b0}) begin
            bad++; $display("FAIL drop_addr got req=%0b addr=%h valid=%0b want req=1 addr=00000120 valid=0", imem_req, imem_addr, if_id_valid);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!if_id_valid) begin
                total++;
                if (imem_addr !== 32'h200) begin
                    bad++; $display("FAIL refetch_addr cycle=%0d got=%h want=00000200", n, imem_addr);
                end
            end
        end while (!if_id_valid && n < 10);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h200, 32'h200} || n != 4) begin
            bad++; $display("FAIL target_arrive got=%0b/%h/%h after=%0d want=1/00000200/00000200 after=4", if_id_valid, if_id_pc, if_id_instr, n);
        end
        latency = 0;
        $display("test_redirect_latency done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_hold_redirect;
        load_use_stall = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL hold_req got=%0b want=0", imem_req);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0; load_use_stall = 1'b0;
        total++;
        if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            bad++; $display("FAIL hold_redir got valid=%0b req=%0b addr=%h want valid=0 req=1 addr=00000300", if_id_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h300, 32'h300}) begin
            bad++; $display("FAIL hold_target got=%0b/%h/%h want=1/00000300/00000300", if_id_valid, if_id_pc, if_id_instr);
        end
        $display("test_hold_redirect done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_align_wrap;
        redirect_valid = 1'b1; redirect_pc = 32'h403;
        @(negedge clk);
        total++;
        if ({if_id_valid, imem_addr} !== {1'b0, 32'h400}) begin
            bad++; $display("FAIL align got valid=%0b addr=%h want valid=0 addr=00000400", if_id_valid, imem_addr);
        end
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if ({if_id_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_req got valid=%0b addr=%h want valid=0 addr=fffffffc", if_id_valid, imem_addr);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL wrap got=%0b/%h addr=%h want=1/fffffffc addr=00000000", if_id_valid, if_id_pc, imem_addr);
        end
        total++;
        if ({if_id_rs1, if_id_rs2} !== {5'd31, 5'd31}) begin
            bad++; $display("FAIL wrap_rs got=%0d/%0d want=31/31", if_id_rs1, if_id_rs2);
        end
        $display("test_align_wrap done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_async_reset;
        latency = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL wait_drop got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, if_id_valid} !== 2'b00) begin
            bad++; $display("FAIL async_rst got req=%0b valid=%0b want req=0 valid=0", imem_req, if_id_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        latency = 0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL rst_restart got req=%0b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, 32'h100, 32'h100, 32'h104}) begin
            bad++; $display("FAIL rst_refetch got=%0b/%h/%h addr=%h want=1/00000100/00000100 addr=00000104", if_id_valid, if_id_pc, if_id_instr, imem_addr);
        end
        $display("test_async_reset done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_latency();
        test_hold_redirect();
        test_align_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. It owns the PC and issues single-outstanding requests to instruction memory. It captures returned instructions into IF/ID and presents rs1/rs2 to the load-use hazard detector. It obeys that detector's stall and the EX-stage redirect (branch/jump flush).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word held in IF/ID when invalid (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising-edge
rst_n  input  1  asynchronous active-low reset
load_use_stall  input  1  hold IF/ID and PC this cycle (from hazard detector)
redirect_valid  input  1  EX resolved taken branch/jump; flush and refetch
redirect_pc  input  32  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, word aligned
imem_rvalid  input  1  response for the current request; may arrive the same cycle as imem_req or later
imem_rdata  input  32  instruction word, valid with imem_rvalid
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  32  PC of IF/ID instruction
if_id_instr  output  32  IF/ID instruction word
if_id_rs1  output  5  if_id_instr[19:15], combinational
if_id_rs2  output  5  if_id_instr[24:20], combinational

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, skid=NOP_INSTR, drop_addr=0. imem_req=0 while rst_n low.
- Memory protocol: one outstanding request. Once imem_req is asserted, imem_addr stays constant until the cycle imem_rvalid=1. imem_rvalid is ignored when imem_req=0.
- redirect_pc[1:0] are forced to 00. PC increment is pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Priority: redirect_valid > load_use_stall > normal fetch.
- State FETCH: imem_req=1, imem_addr=pc.
  - rvalid and no stall, no redirect: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay FETCH.
  - rvalid and stall, no redirect: skid <= imem_rdata; IF/ID held; pc held; go HOLD.
  - no rvalid and no stall, no redirect: if_id_valid <= 0 (bubble; pc/instr fields may hold); stay FETCH.
  - no rvalid and stall, no redirect: everything held.
  - redirect with rvalid: response discarded; pc <= redirect_pc; if_id_valid <= 0; stay FETCH.
  - redirect without rvalid: drop_addr <= pc; pc <= redirect_pc; if_id_valid <= 0; go WAIT_DROP.
- State WAIT_DROP: imem_req=1, imem_addr=drop_addr. IF/ID stays invalid and stall is ignored.
  - rvalid: data discarded; go FETCH.
  - Another redirect: pc <= new target. If rvalid arrives in the same cycle, go FETCH; otherwise stay in WAIT_DROP.
- State HOLD: imem_req=0. The skid buffer holds the instruction at pc.
  - Stall held: everything held.
  - Stall released, no redirect: IF/ID <= {1, pc, skid}; pc <= pc+4; go FETCH. The next request issues in the same cycle as the IF/ID load.
  - redirect: skid dropped; pc <= redirect_pc; if_id_valid <= 0; go FETCH.
- Latency: with a zero-wait memory, the instruction at address A appears in IF/ID one cycle after A is requested. Steady state is 1 instr/cycle.
- A redirect always yields exactly one invalid IF/ID cycle before the target instruction at the earliest.
- A stall never loses or duplicates an instruction. A redirect never lets a wrong-path instruction become valid.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory returning addr as data -> imem_addr 0x100,0x104,0x108 on successive cycles; IF/ID {1,0x100,0x100} one cycle after the first request; if_id_rs1/rs2 equal instr[19:15]/[24:20].
- Zero-wait fetch, load_use_stall high for 2 cycles when pc=0x108 -> IF/ID holds 0x104 for both stall cycles; after release 0x108 then 0x10C appear with no gap or duplicate.
- 3-cycle memory latency, redirect to 0x200 one cycle after the request to 0x120 -> imem_addr stays 0x120 until rvalid; that data is discarded; next request is 0x200; if_id_valid stays 0 until 0x200 arrives.
- Stall plus same-cycle rvalid (enter HOLD), then redirect to 0x300 while stalled -> skid discarded, if_id_valid=0, next imem_addr=0x300.
- redirect_pc=0x403 -> imem_addr=0x400. pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
- Assert rst_n low mid-WAIT_DROP -> imem_req=0 and if_id_valid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC in FETCH.
